// File: rtl/std_dffe_rr_arbiter.sv
// Round-robin arbiter sharing the single en/d write port of one enabled register among REQ_COUNT requesters.
// Grant locking (req_lock / LOCKED state) is compiled in only when STD_DFFE_ARB_LOCK_EN is defined.

module std_dffe_rr_arbiter #(
    parameter int REQ_COUNT  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [REQ_COUNT-1:0]            req_valid,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] req_data,
    input  logic [REQ_COUNT-1:0]            req_lock,
    output logic [REQ_COUNT-1:0]            req_ready,
    output logic                            dffe_en,
    output logic [DATA_WIDTH-1:0]           dffe_d,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            grant_valid,
    output logic                            locked
);

    localparam logic [ID_WIDTH:0]   REQ_COUNT_EXT = (ID_WIDTH+1)'(REQ_COUNT);
    localparam logic [ID_WIDTH-1:0] LAST_ID       = ID_WIDTH'(REQ_COUNT - 1);

    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic                  r_grant_valid;

    logic                  w_rr_found;
    logic [ID_WIDTH-1:0]   w_rr_idx;
    logic                  w_grant_any;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic [REQ_COUNT-1:0]  w_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_data;
    logic [ID_WIDTH-1:0]   w_next_ptr;

    // Search starts at the pointer; the sum is one bit wider so the wrap happens at
    // REQ_COUNT rather than at 2^ID_WIDTH.
    always_comb begin
        logic [ID_WIDTH:0] v_sum;
        // NOTE: every output of a combinational block gets a default before any branch, so no latch can be inferred.
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        v_sum      = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (v_sum >= REQ_COUNT_EXT) begin
                v_sum = v_sum - REQ_COUNT_EXT;
            end
            if (!w_rr_found && req_valid[v_sum[ID_WIDTH-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = v_sum[ID_WIDTH-1:0];
            end
        end
    end

`ifdef STD_DFFE_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_WIDTH-1:0] r_owner;
    logic [ID_WIDTH-1:0] w_owner_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
        end
    end

    // Every accepted beat re-evaluates the lock, so an unlocked beat from the owner releases the bank.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        if (w_accept) begin
            if (req_lock[w_grant_idx]) begin
                w_state_next = ST_LOCKED;
                w_owner_next = w_grant_idx;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
    end

    assign w_grant_any = (r_state == ST_LOCKED) || w_rr_found;
    assign w_grant_idx = (r_state == ST_LOCKED) ? r_owner : w_rr_idx;
    assign locked      = (r_state == ST_LOCKED);
`else
    wire w_unused_lock = ^req_lock;

    assign w_grant_any = w_rr_found;
    assign w_grant_idx = w_rr_idx;
    assign locked      = 1'b0;
`endif

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (w_grant_any && (w_grant_idx == ID_WIDTH'(i))) begin
                w_ready[i] = 1'b1;
            end
        end
    end

    assign req_ready = resetn ? w_ready : '0;
    assign w_accept  = |(req_valid & req_ready);

    // req_ready is one-hot, so OR-ing the gated slices acts as the data mux.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (req_ready[i]) begin
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign dffe_en    = w_accept;
    assign dffe_d     = w_accept ? w_data : '0;
    assign w_next_ptr = (w_grant_idx == LAST_ID) ? '0 : w_grant_idx + ID_WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_grant_valid <= w_accept;
            if (w_accept) begin
                r_rr_ptr   <= w_next_ptr;
                r_grant_id <= w_grant_idx;
            end
        end
    end

    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_std_dffe_rr_arbiter.sv
// Scoreboard bench for std_dffe_rr_arbiter: a 4-requester instance plus a 3-requester instance for pointer wrap.
// Expected grant/data/lock values come from per-test stimulus tables; the shared register is modelled here.

module tb_std_dffe_rr_arbiter;

    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_lock  = '0;
    logic [DW-1:0]   data_arr [N];
    wire  [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            dffe_en;
    logic [DW-1:0]   dffe_d;
    logic [IW-1:0]   grant_id;
    logic            grant_valid;
    logic            locked;

    logic [N3-1:0]    v3  = '0;
    logic [N3-1:0]    lk3 = '0;
    logic [DW-1:0]    data3_arr [N3];
    wire  [N3*DW-1:0] d3;
    logic [N3-1:0]    ready3;
    logic             en3;
    logic [DW-1:0]    dd3;
    logic [IW-1:0]    gid3;
    logic             gv3;
    logic             locked3;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack4
        assign req_data[gi*DW +: DW] = data_arr[gi];
    end
    for (genvar gi = 0; gi < N3; gi++) begin : g_pack3
        assign d3[gi*DW +: DW] = data3_arr[gi];
    end

    std_dffe_rr_arbiter #(.REQ_COUNT(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) u_dut4 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .dffe_en(dffe_en), .dffe_d(dffe_d),
        .grant_id(grant_id), .grant_valid(grant_valid), .locked(locked)
    );

    std_dffe_rr_arbiter #(.REQ_COUNT(N3), .DATA_WIDTH(DW), .ID_WIDTH(IW)) u_dut3 (
        .clk(clk), .resetn(resetn), .req_valid(v3), .req_data(d3),
        .req_lock(lk3), .req_ready(ready3), .dffe_en(en3), .dffe_d(dd3),
        .grant_id(gid3), .grant_valid(gv3), .locked(locked3)
    );

    // Shared register fed by the arbiter's write port; deliberately not reset.
    logic [DW-1:0] shared_q = '0;
    always @(posedge clk) begin
        if (dffe_en) shared_q <= dffe_d;
    end

    typedef struct packed {
        logic          gv;
        logic [IW-1:0] gid;
        logic [DW-1:0] q;
    } reg_exp_t;

    reg_exp_t      reg_q [$];
    logic [IW-1:0] exp_gid = '0;
    logic [DW-1:0] exp_q   = '0;
    logic [N-1:0]  pend    = '0;
    int            n_cmp   = 0;
    int            n_fail  = 0;

    task automatic apply_reset(input string tag);
        resetn = 1'b0;
        #1;
        n_cmp++; if (req_ready !== '0)   begin n_fail++; $display("FAIL %s req_ready: got %b want 0000", tag, req_ready); end
        n_cmp++; if (dffe_en !== 1'b0)   begin n_fail++; $display("FAIL %s dffe_en: got %b want 0", tag, dffe_en); end
        n_cmp++; if (locked !== 1'b0)    begin n_fail++; $display("FAIL %s locked: got %b want 0", tag, locked); end
        n_cmp++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL %s grant_valid: got %b want 0", tag, grant_valid); end
        n_cmp++; if (grant_id !== '0)    begin n_fail++; $display("FAIL %s grant_id: got %0d want 0", tag, grant_id); end
        n_cmp++; if (ready3 !== '0 || en3 !== 1'b0 || gv3 !== 1'b0 || gid3 !== '0 || locked3 !== 1'b0) begin
            n_fail++; $display("FAIL %s dut3 reset: ready %b en %b gv %b gid %0d locked %b want all 0", tag, ready3, en3, gv3, gid3, locked3);
        end
        req_valid = '0; req_lock = '0; v3 = '0; lk3 = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        pend    = '0;
        exp_gid = '0;
        reg_q.delete();
        reg_q.push_back('{1'b0, '0, exp_q});
    endtask

    // Drives one cycle on the 4-requester DUT; g is the expected winner (-1 = none).
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] lk, input int g,
                         input logic exp_lk, input string tag);
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_d;
        reg_exp_t      exp_r;
        reg_exp_t      got_r;
        if ((pend & ~(v & lk)) != '0) begin
            n_fail++; $display("FAIL %s contract: pending %b withdrawn (valid %b lock %b)", tag, pend, v, lk);
        end
        req_valid = v;
        req_lock  = lk;
        exp_ready = '0;
        exp_d     = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_d        = data_arr[g];
        end
        @(negedge clk);
        n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL %s req_ready: got %b want %b", tag, req_ready, exp_ready); end
        n_cmp++; if (dffe_en !== (g >= 0))     begin n_fail++; $display("FAIL %s dffe_en: got %b want %b", tag, dffe_en, (g >= 0)); end
        n_cmp++; if (dffe_d !== exp_d)         begin n_fail++; $display("FAIL %s dffe_d: got %h want %h", tag, dffe_d, exp_d); end
        n_cmp++; if (locked !== exp_lk)        begin n_fail++; $display("FAIL %s locked: got %b want %b", tag, locked, exp_lk); end
        n_cmp++;
        if (reg_q.size() == 0) begin
            n_fail++; $display("FAIL %s scoreboard: got empty queue want one entry", tag);
        end else begin
            exp_r = reg_q.pop_front();
            got_r = {grant_valid, grant_id, shared_q};
            if (got_r !== exp_r) begin
                n_fail++;
                $display("FAIL %s registered gv/gid/q: got %b/%0d/%h want %b/%0d/%h",
                         tag, got_r.gv, got_r.gid, got_r.q, exp_r.gv, exp_r.gid, exp_r.q);
            end
        end
        pend = v & lk & ~req_ready;
        if (g >= 0) begin
            exp_gid = IW'(g);
            exp_q   = exp_d;
        end
        reg_q.push_back('{(g >= 0), exp_gid, exp_q});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset("reset");
        cycle(4'b0000, 4'b0000, -1, 1'b0, "idle0");
        cycle(4'b0000, 4'b0000, -1, 1'b0, "idle1");
    endtask

    task automatic test_single();
        apply_reset("single_rst");
        for (int i = 0; i < N; i++) data_arr[i] = 32'h1100_0000 + 32'(i);
        data_arr[2] = 32'hDEAD_BEEF;
        cycle(4'b0100, 4'b0000, 2, 1'b0, "single");
        data_arr[2] = 32'h2222_0002;
        cycle(4'b1111, 4'b0000, 3, 1'b0, "single_ptr");
        cycle(4'b0000, 4'b0000, -1, 1'b0, "single_tail");
    endtask

    task automatic test_contention();
        apply_reset("cont_rst");
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) data_arr[i] = (32'(k) << 16) | (32'(i) << 4) | 32'hC000_0000;
            cycle(4'b1111, 4'b0000, k % N, 1'b0, $sformatf("cont%0d", k));
        end
        cycle(4'b0000, 4'b0000, -1, 1'b0, "cont_tail");
    endtask

    task automatic test_wrap3();
        logic [N3-1:0] v_t [5] = '{3'b001, 3'b010, 3'b111, 3'b011, 3'b111};
        int            g_t [5] = '{0, 1, 2, 0, 1};
        int            q3 [$];
        int            g;
        logic [N3-1:0] exp_ready;
        logic [IW-1:0] egid;
        logic          egv;
        apply_reset("wrap3_rst");
        for (int i = 0; i < N3; i++) data3_arr[i] = 32'h3000_0000 + 32'(i);
        egid = '0;
        egv  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v3 = v_t[k];
            q3.push_back(g_t[k]);
            @(negedge clk);
            g = q3.pop_front();
            exp_ready    = '0;
            exp_ready[g] = 1'b1;
            n_cmp++; if (ready3 !== exp_ready)   begin n_fail++; $display("FAIL wrap3_%0d req_ready: got %b want %b", k, ready3, exp_ready); end
            n_cmp++; if (en3 !== 1'b1)           begin n_fail++; $display("FAIL wrap3_%0d dffe_en: got %b want 1", k, en3); end
            n_cmp++; if (dd3 !== data3_arr[g])   begin n_fail++; $display("FAIL wrap3_%0d dffe_d: got %h want %h", k, dd3, data3_arr[g]); end
            n_cmp++; if (gid3 !== egid || gv3 !== egv) begin
                n_fail++; $display("FAIL wrap3_%0d grant_id/valid: got %0d/%b want %0d/%b", k, gid3, gv3, egid, egv);
            end
            egid = IW'(g);
            egv  = 1'b1;
            @(posedge clk);
            #1;
        end
        v3 = '0;
        @(negedge clk);
        n_cmp++; if (gid3 !== egid || gv3 !== 1'b1 || en3 !== 1'b0) begin
            n_fail++; $display("FAIL wrap3_tail gid/gv/en: got %0d/%b/%b want %0d/1/0", gid3, gv3, en3, egid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        logic [N-1:0] v_t  [5];
        logic [N-1:0] lk_t [5];
        int           g_t  [5];
        logic         lkd_t [5];
`ifdef STD_DFFE_ARB_LOCK_EN
        v_t   = '{4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0101};
        lk_t  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        g_t   = '{1, 1, 1, 2, 0};
        lkd_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        v_t   = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0101};
        lk_t  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        g_t   = '{1, 2, 0, 1, 2};
        lkd_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        apply_reset("lock_rst");
        for (int i = 0; i < N; i++) data_arr[i] = 32'h4000_0000 + 32'(i);
        cycle(4'b0001, 4'b0000, 0, 1'b0, "lock_pre");
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) data_arr[i] = 32'h4000_0000 | (32'(k) << 8) | 32'(i);
            cycle(v_t[k], lk_t[k], g_t[k], lkd_t[k], $sformatf("lock%0d", k));
        end
        cycle(4'b0000, 4'b0000, -1, 1'b0, "lock_tail");
    endtask

    task automatic test_reset_mid_lock();
`ifdef STD_DFFE_ARB_LOCK_EN
        logic exp_lk = 1'b1;
`else
        logic exp_lk = 1'b0;
`endif
        apply_reset("midlock_rst");
        for (int i = 0; i < N; i++) data_arr[i] = 32'h5000_0000 + 32'(i);
        cycle(4'b0010, 4'b0010, 1, 1'b0, "midlock0");
        data_arr[1] = 32'h5555_0001;
        cycle(4'b0010, 4'b0010, 1, exp_lk, "midlock1");
        req_valid   = 4'b0010;
        req_lock    = 4'b0010;
        data_arr[1] = 32'hBAD0_BAD0;
        #2;
        apply_reset("midlock_async");
        for (int i = 0; i < N; i++) data_arr[i] = 32'h6000_0000 + 32'(i);
        cycle(4'b0110, 4'b0000, 1, 1'b0, "midlock_after");
        cycle(4'b0000, 4'b0000, -1, 1'b0, "midlock_tail");
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_arr[i] = '0;
        for (int i = 0; i < N3; i++) data3_arr[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap3();
        test_lock();
        test_reset_mid_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
